// File: rtl/cla_multiword_sequencer.sv
// Multi-cycle wide add/subtract built from one 16-bit carry-lookahead adder.
// Slices are processed least significant first. Each slice's carry-out is
// registered and feeds the next slice's carry-in.

// 16-bit two-level carry-lookahead adder (four 4-bit groups).
module cla16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  output logic [15:0] s_o,
  output logic        c_o
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  // Group generate/propagate, group carries, then per-bit carries inside each group.
  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;
    for (int unsigned k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = c_i;
    gc[1] = gg[0] | (gp[0] & c_i);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_i);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_i);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c_i);
    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    s_o = p ^ c;
    c_o = gc[4];
  end
endmodule

module cla_multiword_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic                c_out,
  output logic                overflow,
  output logic                busy
);
  localparam int unsigned W    = 16 * WORDS;
  localparam int unsigned IDXW = $clog2(WORDS);
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [IDXW+3:0] base;
  logic [15:0]     a_sl, b_sl, add_s;
  logic            add_c;

  assign base = {idx_q, 4'b0000};
  assign a_sl = a_q[base +: 16];
  assign b_sl = b_q[base +: 16];

  cla16 u_cla (
    .a_i (a_sl),
    .b_i (b_sl),
    .c_i (carry_q),
    .s_o (add_s),
    .c_o (add_c)
  );

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update; b is stored pre-inverted for subtract.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: 16] = add_s;
        carry_d           = add_c;
        if (idx_q == LAST) begin
          cout_d  = add_c;
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (add_s[15] != a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign c_out     = cout_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Bench for cla_multiword_sequencer: directed cases on a 4-word instance,
// then concurrent random sweeps on 4-word and 2-word instances.
module tb_cla_multiword_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        iv4 = 1'b0, sub4 = 1'b0, or4 = 1'b0;
  logic [63:0] a4 = '0, b4 = '0;
  logic        ir4, ov4, bz4, c4, o4;
  logic [63:0] s4;

  logic        iv2 = 1'b0, sub2 = 1'b0, or2 = 1'b0;
  logic [31:0] a2 = '0, b2 = '0;
  logic        ir2, ov2, bz2, c2, o2;
  logic [31:0] s2;

  cla_multiword_sequencer #(.WORDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .sub(sub4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .c_out(c4), .overflow(o4), .busy(bz4)
  );

  cla_multiword_sequencer #(.WORDS(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .sub(sub2),
    .out_valid(ov2), .out_ready(or2), .sum(s2), .c_out(c2), .overflow(o2), .busy(bz2)
  );

  int pass_n = 0;
  int total_n = 0;

  // Reference state per instance: is an operation outstanding, how many edges since acceptance.
  bit          pend[2];
  int          cnt[2];
  logic [63:0] es[2];
  logic        ec[2], eo[2];
  int          done_n[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Wide arithmetic from first principles: modular sum/difference, unsigned carry/no-borrow, signed overflow.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s, input int w,
                                output logic [63:0] r, output logic c, output logic o);
    logic [64:0] full;
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'h1 << w) - 64'h1);
    if (s) begin
      r = (a - b) & mask;
      c = (a >= b);
      o = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      r = full[63:0] & mask;
      c = full[w];
      o = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
    end
  endfunction

  function automatic logic [63:0] rndw(input int w);
    logic [63:0] m, r;
    m = (w == 64) ? '1 : ((64'h1 << w) - 64'h1);
    case ($urandom % 8)
      0: r = m;
      1: r = '0;
      2: r = 64'h1 << (w - 1);
      3: r = (64'h1 << (w - 1)) - 64'h1;
      4: r = 64'h1;
      default: r = {$urandom, $urandom} & m;
    endcase
    return r;
  endfunction

  task automatic mon(input int k, input int wd, input string p,
                     input logic iv, input logic [63:0] a, input logic [63:0] b, input logic sb,
                     input logic ordy, input logic ir, input logic ov, input logic bz,
                     input logic [63:0] s, input logic c, input logic o);
    bit exp_ov;
    if (rst) begin
      pend[k] = 1'b0;
      chk({p, " rst in_ready"}, 64'(ir), 64'd1);
      chk({p, " rst out_valid"}, 64'(ov), 64'd0);
      chk({p, " rst busy"}, 64'(bz), 64'd0);
      chk({p, " rst sum"}, s, 64'd0);
      chk({p, " rst c_out"}, 64'(c), 64'd0);
      chk({p, " rst overflow"}, 64'(o), 64'd0);
      return;
    end
    exp_ov = pend[k] && (cnt[k] >= wd);
    chk({p, " in_ready"}, 64'(ir), 64'(!pend[k]));
    chk({p, " busy"}, 64'(bz), 64'(pend[k]));
    chk({p, " out_valid"}, 64'(ov), 64'(exp_ov));
    if (exp_ov) begin
      chk({p, " sum"}, s, es[k]);
      chk({p, " c_out"}, 64'(c), 64'(ec[k]));
      chk({p, " overflow"}, 64'(o), 64'(eo[k]));
    end
    // Predict the effect of the coming rising edge.
    if (pend[k]) begin
      if (exp_ov && ordy) begin
        pend[k] = 1'b0;
        done_n[k]++;
      end else if (cnt[k] < wd) begin
        cnt[k]++;
      end
    end else if (iv) begin
      pend[k] = 1'b1;
      cnt[k] = 0;
      model(a, b, sb, 16 * wd, es[k], ec[k], eo[k]);
    end
  endtask

  always @(negedge clk) begin
    mon(0, 4, "w4", iv4, a4, b4, sub4, or4, ir4, ov4, bz4, s4, c4, o4);
    mon(1, 2, "w2", iv2, 64'(a2), 64'(b2), sub2, or2, ir2, ov2, bz2, 64'(s2), c2, o2);
  end

  // Called at posedge+1 with the 4-word instance idle; returns just after the acceptance edge.
  task automatic start4(input logic [63:0] a, input logic [63:0] b, input logic s, input bit noise);
    a4 = a; b4 = b; sub4 = s; iv4 = 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      a4 = rndw(64); b4 = rndw(64); sub4 = ~s;
    end else begin
      iv4 = 1'b0;
    end
  endtask

  task automatic run4(input string nm, input logic [63:0] a, input logic [63:0] b, input logic s,
                      input logic [63:0] xs, input logic xc, input logic xo, input bit hold);
    int n;
    or4 = !hold;
    start4(a, b, s, hold);
    n = 0;
    while (ov4 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (hold) begin a4 = rndw(64); b4 = rndw(64); end
    end
    chk({nm, " latency"}, 64'(n), 64'd4);
    chk({nm, " sum"}, s4, xs);
    chk({nm, " c_out"}, 64'(c4), 64'(xc));
    chk({nm, " overflow"}, 64'(o4), 64'(xo));
    if (hold) begin
      repeat (10) begin
        @(posedge clk); #1;
        chk({nm, " held out_valid"}, 64'(ov4), 64'd1);
        chk({nm, " held in_ready"}, 64'(ir4), 64'd0);
        chk({nm, " held sum"}, s4, xs);
        chk({nm, " held c_out"}, 64'(c4), 64'(xc));
        chk({nm, " held overflow"}, 64'(o4), 64'(xo));
        a4 = rndw(64);
        iv4 = 1'($urandom % 2);
      end
      iv4 = 1'b0;
      or4 = 1'b1;
    end
    @(posedge clk); #1;
    chk({nm, " out_valid dropped"}, 64'(ov4), 64'd0);
    chk({nm, " in_ready after"}, 64'(ir4), 64'd1);
    or4 = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    logic        c, o;
    int          cyc4, cyc2;

    model(64'hFFFF, 64'h1, 1'b0, 64, r, c, o);
    chk("model add", r, 64'h10000);
    model(64'h0, 64'h1, 1'b1, 64, r, c, o);
    chk("model borrow", {r[62:0], c}, {63'h7FFF_FFFF_FFFF_FFFF, 1'b0});
    model(64'h8000_0000_0000_0000, 64'h1, 1'b1, 64, r, c, o);
    chk("model sub ovf", {61'd0, c, o, r[63]}, 64'b110);
    model(64'hFFFF_FFFF, 64'h1, 1'b0, 32, r, c, o);
    chk("model w32 wrap", {r[62:0], c}, 64'h1);

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run4("add16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    run4("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    run4("sub borrow", 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run4("sub ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run4("hold", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
    run4("after hold", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

    start4(64'h1, 64'h2, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrun rst in_ready", 64'(ir4), 64'd1);
    chk("midrun rst out_valid", 64'(ov4), 64'd0);
    chk("midrun rst busy", 64'(bz4), 64'd0);
    chk("midrun rst sum", s4, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("no stale result", 64'(ov4), 64'd0);
    end
    run4("post rst", 64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b0, 1'b0);

    cyc4 = 0;
    cyc2 = 0;
    fork
      begin
        logic [63:0] rr;
        while (done_n[0] < 1000 && cyc4 < 40000) begin
          @(posedge clk); #1;
          rr = rndw(64); a4 = rr;
          rr = rndw(64); b4 = rr;
          sub4 = 1'($urandom % 2);
          iv4 = ($urandom % 4) != 0;
          or4 = ($urandom % 3) != 0;
          cyc4++;
        end
        iv4 = 1'b0;
        or4 = 1'b1;
      end
      begin
        logic [63:0] rr;
        while (done_n[1] < 1000 && cyc2 < 40000) begin
          @(posedge clk); #1;
          rr = rndw(32); a2 = rr[31:0];
          rr = rndw(32); b2 = rr[31:0];
          sub2 = 1'($urandom % 2);
          iv2 = ($urandom % 4) != 0;
          or2 = ($urandom % 3) != 0;
          cyc2++;
        end
        iv2 = 1'b0;
        or2 = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    chk("w4 random ops completed", 64'(done_n[0] >= 1000), 64'd1);
    chk("w2 random ops completed", 64'(done_n[1] >= 1000), 64'd1);
    chk("w4 drained", 64'(ir4), 64'd1);
    chk("w2 drained", 64'(ir2), 64'd1);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
